// File: rtl/wb_regfile_stage_if.sv
// Bundles the EX-to-WB capture, ID read ports and WB status signals of wb_regfile_stage.
// The master side is the pipeline (EX/ID); the slave side is the write-back stage.
interface wb_regfile_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_result;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wb_valid;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              halted;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    output ex_valid, ex_opcode, ex_rd, ex_result, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_we, wb_rd, wb_data, halted, retired_cnt
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_rd, ex_result, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_we, wb_rd, wb_data, halted, retired_cnt
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// Write-back stage: WB pipeline register, 16x8 flop register file, retire counter, sticky HALT.
// Optional macro WB_BYPASS_EN forwards the pending WB result onto the read ports.
module wb_regfile_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rstn,
  wb_regfile_stage_if.slave bus
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q,    wb_we_d;
  logic [ADDR_W-1:0] wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic              halted_q,   halted_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              capture;
  logic [DATA_W-1:0] rs1_c, rs2_c;

  // Next-state for the WB register, HALT flag and retire counter
  always_comb begin
    capture    = bus.ex_valid && !halted_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    if (capture) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = bus.ex_rd;
      wb_data_d  = bus.ex_result;
      wb_we_d    = (bus.ex_opcode != OP_NOP) && (bus.ex_opcode != OP_HALT) &&
                   (bus.ex_rd != '0);
      if (bus.ex_opcode == OP_HALT) halted_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  // Commit; r0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wb_we_q && (wb_rd_q != '0)) begin
      regs_q[wb_rd_q] <= wb_data_q;
    end
  end

  always_comb begin
    rs1_c = regs_q[bus.rs1_addr];
`ifdef WB_BYPASS_EN
    if (wb_we_q && (bus.rs1_addr == wb_rd_q)) rs1_c = wb_data_q;
`endif
    if (bus.rs1_addr == '0) rs1_c = '0;
  end

  always_comb begin
    rs2_c = regs_q[bus.rs2_addr];
`ifdef WB_BYPASS_EN
    if (wb_we_q && (bus.rs2_addr == wb_rd_q)) rs2_c = wb_data_q;
`endif
    if (bus.rs2_addr == '0) rs2_c = '0;
  end

  assign bus.rs1_data    = rs1_c;
  assign bus.rs2_data    = rs2_c;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.halted      = halted_q;
  assign bus.retired_cnt = cnt_q;

endmodule
